cache_miss_scheduler: RTL

Sequences miss returns for the cache latency emulator. Accepts miss requests (address plus per-address latency from the latency RAM), holds them in a small outstanding-miss table, counts each entry's latency down, and returns at most one completed address per cycle on the emulator's response port (`addr_response` / `addr_response_valid`). Repeat misses to an already-outstanding address merge into the existing entry, so each address returns only once.

---
 rtl/cache_miss_scheduler.sv | 121 ++++++++++++
 1 files changed

// File: rtl/cache_miss_scheduler.sv
// rtl/cache_miss_scheduler.sv - outstanding-miss table that counts latency down and returns one address per cycle
module cache_miss_scheduler #(
    parameter int ENTRIES = 8,
    parameter int ADDR_W  = 27,
    parameter int LAT_W   = 5,
    localparam int IDX_W  = $clog2(ENTRIES),
    localparam int CNT_W  = $clog2(ENTRIES) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LAT_W-1:0]  req_latency,
    output logic              req_ready,
    output logic              req_merged,
    output logic              resp_valid,
    output logic [ADDR_W-1:0] resp_addr,
    output logic [CNT_W-1:0]  pending_count
);

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [ADDR_W-1:0]  addr_q [ENTRIES];
    logic [ADDR_W-1:0]  addr_d [ENTRIES];
    logic [LAT_W-1:0]   cnt_q  [ENTRIES];
    logic [LAT_W-1:0]   cnt_d  [ENTRIES];
    logic               resp_valid_q, resp_valid_d;
    logic [ADDR_W-1:0]  resp_addr_q, resp_addr_d;
    logic [CNT_W-1:0]   pending_q, pending_d;

    logic               issue_en;
    logic [IDX_W-1:0]   issue_idx;
    logic               free_en;
    logic [IDX_W-1:0]   free_idx;
    logic [ENTRIES-1:0] match_vec;
    logic               any_match;
    logic               alloc_en;
    logic [LAT_W-1:0]   lat_eff;

    // Descending scans so the lowest index is the last assignment to stick.
    always_comb begin
        issue_en  = 1'b0;
        issue_idx = '0;
        free_en   = 1'b0;
        free_idx  = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (valid_q[i] && cnt_q[i] == '0) begin
                issue_en  = 1'b1;
                issue_idx = IDX_W'(i);
            end
            if (!valid_q[i]) begin
                free_en  = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        match_vec = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            match_vec[i] = valid_q[i] && (addr_q[i] == req_addr)
                           && !(issue_en && issue_idx == IDX_W'(i));
        end
    end

    assign any_match  = |match_vec;
    assign req_ready  = any_match || free_en;
    assign req_merged = req_valid && any_match;
    assign alloc_en   = req_valid && !any_match && free_en;

    // The allocating edge is the first countdown edge, so store one less than the latency.
    assign lat_eff = (req_latency == '0) ? '0 : req_latency - LAT_W'(1);

    always_comb begin
        valid_d      = valid_q;
        resp_valid_d = issue_en;
        resp_addr_d  = issue_en ? addr_q[issue_idx] : resp_addr_q;
        pending_d    = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            addr_d[i] = addr_q[i];
            cnt_d[i]  = (cnt_q[i] != '0) ? cnt_q[i] - LAT_W'(1) : '0;
            if (issue_en && issue_idx == IDX_W'(i)) begin
                valid_d[i] = 1'b0;
            end
            if (alloc_en && free_idx == IDX_W'(i)) begin
                valid_d[i] = 1'b1;
                addr_d[i]  = req_addr;
                cnt_d[i]   = lat_eff;
            end
        end
        for (int i = 0; i < ENTRIES; i++) begin
            pending_d = pending_d + {{(CNT_W-1){1'b0}}, valid_d[i]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_addr_q  <= '0;
            pending_q    <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                addr_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            valid_q      <= valid_d;
            resp_valid_q <= resp_valid_d;
            resp_addr_q  <= resp_addr_d;
            pending_q    <= pending_d;
            for (int i = 0; i < ENTRIES; i++) begin
                addr_q[i] <= addr_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
        end
    end

    assign resp_valid    = resp_valid_q;
    assign resp_addr     = resp_addr_q;
    assign pending_count = pending_q;

endmodule
